// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage in front of the ALU: register file read, busy-bit
// scoreboard for RAW/WAW hazards, writeback forwarding, registered outputs.
module alu_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_alu_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] out_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  function automatic logic wb_hits(input logic [ADDR_W-1:0] r);
    return wb_en && (wb_rd == r) && (r != '0);
  endfunction

  // A busy source is no hazard if its writeback lands this very cycle.
  function automatic logic blocked(input logic [ADDR_W-1:0] r);
    return (r != '0) && busy[r] && !wb_hits(r);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hazard  = 1'b0;
    rs1_val = '0;
    rs2_val = '0;
    if (blocked(in_rs1))                hazard = 1'b1;
    if (!in_use_imm && blocked(in_rs2)) hazard = 1'b1;
    if (blocked(in_rd))                 hazard = 1'b1;

    if (wb_hits(in_rs1))      rs1_val = wb_data;
    else if (in_rs1 != '0)    rs1_val = regs[in_rs1];

    if (in_use_imm)           rs2_val = in_imm;
    else if (wb_hits(in_rs2)) rs2_val = wb_data;
    else if (in_rs2 != '0)    rs2_val = regs[in_rs2];
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only; the busy-set
  // for an accept is written after the writeback clear so that set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is reset explicitly because the stage must
      // come up with every register reading as zero.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy      <= '0;
      out_valid <= 1'b0;
      alu_op    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      out_rd    <= '0;
    end else begin
      if (wb_en && wb_rd != '0) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        alu_op    <= in_alu_op;
        op_a      <= rs1_val;
        op_b      <= rs2_val;
        out_rd    <= in_rd;
        if (in_rd != '0) busy[in_rd] <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed self-checking bench for alu_operand_fetch: reset, forwarding,
// hazards, immediates, backpressure, register 0 and reset mid-stall.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_use_imm;
  logic [4:0]  in_alu_op, in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [4:0]  alu_op, out_rd;
  logic [31:0] op_a, op_b;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic use_imm, input logic [31:0] imm);
    in_valid = 1'b1; in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_use_imm = use_imm; in_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_alu_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_imm = 0; in_use_imm = 0; out_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0;
    tick(); tick();
    to_neg(); rst = 1'b0; #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);

    // Basic issue after writing r1=3, r2=1
    wb_en = 1; wb_rd = 1; wb_data = 32'h3; tick();
    to_neg(); wb_rd = 2; wb_data = 32'h1; tick();
    to_neg(); wb_en = 0;
    issue(5'b01010, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0); #1;
    check("basic_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_op_a", op_a, 32'h3);
    check("basic_op_b", op_b, 32'h1);
    check("basic_alu_op", 32'(alu_op), 32'(5'b01010));
    check("basic_out_rd", 32'(out_rd), 32'd3);

    // RAW on r3, resolved by same-cycle writeback forwarding
    to_neg(); issue(5'd1, 5'd3, 5'd0, 5'd4, 1'b0, 32'h0); #1;
    check("raw_stall", 32'(in_ready), 32'd0);
    tick();
    check("raw_drain", 32'(out_valid), 32'd0);
    to_neg(); #1;
    check("raw_stall2", 32'(in_ready), 32'd0);
    wb_en = 1; wb_rd = 3; wb_data = 32'h4; #1;
    check("raw_fwd_ready", 32'(in_ready), 32'd1);
    tick();
    check("raw_out_valid", 32'(out_valid), 32'd1);
    check("raw_fwd_op_a", op_a, 32'h4);
    check("raw_out_rd", 32'(out_rd), 32'd4);

    // Immediate ignores busy rs2
    to_neg(); wb_en = 0;
    issue(5'd2, 5'd1, 5'd0, 5'd5, 1'b1, 32'h7); tick();
    to_neg(); issue(5'd3, 5'd3, 5'd5, 5'd6, 1'b1, 32'hFFFF_FFF0); #1;
    check("imm_no_stall", 32'(in_ready), 32'd1);
    tick();
    check("imm_op_b", op_b, 32'hFFFF_FFF0);
    check("imm_op_a", op_a, 32'h4);
    check("imm_out_rd", 32'(out_rd), 32'd6);

    // Backpressure: outputs hold for three cycles
    to_neg(); out_ready = 0;
    issue(5'b10001, 5'd2, 5'd1, 5'd7, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_op_b", op_b, 32'hFFFF_FFF0);
      check("bp_hold_rd", 32'(out_rd), 32'd6);
      to_neg();
    end
    out_ready = 1; #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_op_a", op_a, 32'h1);
    check("bp_next_op_b", op_b, 32'h3);
    check("bp_next_alu_op", 32'(alu_op), 32'(5'b10001));
    check("bp_next_rd", 32'(out_rd), 32'd7);

    // WAW: r7 still busy
    to_neg(); issue(5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 32'h0); #1;
    check("waw_stall", 32'(in_ready), 32'd0);

    // Register 0
    to_neg(); in_valid = 0; wb_en = 1; wb_rd = 0; wb_data = 32'hDEAD_BEEF; tick();
    to_neg(); wb_en = 0; issue(5'd4, 5'd0, 5'd0, 5'd0, 1'b1, 32'h55); #1;
    check("r0_ready", 32'(in_ready), 32'd1);
    tick();
    check("r0_op_a", op_a, 32'h0);
    check("r0_out_rd", 32'(out_rd), 32'd0);
    to_neg(); #1;
    check("r0_not_busy", 32'(in_ready), 32'd1);
    tick();

    // Reset mid-stall
    to_neg(); issue(5'd5, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0); tick();
    to_neg(); out_ready = 0; issue(5'd6, 5'd3, 5'd1, 5'd8, 1'b0, 32'h0); #1;
    check("ms_stall", 32'(in_ready), 32'd0);
    rst = 1; tick();
    check("ms_rst_valid", 32'(out_valid), 32'd0);
    check("ms_rst_op_a", op_a, 32'h0);
    to_neg(); rst = 0; #1;
    check("ms_ready", 32'(in_ready), 32'd1);
    tick();
    check("ms_out_valid", 32'(out_valid), 32'd1);
    check("ms_op_a", op_a, 32'h0);
    check("ms_op_b", op_b, 32'h0);
    check("ms_out_rd", 32'(out_rd), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the ALU.
- Accepts decoded instructions (alu_op, rs1, rs2, rd, immediate) over a valid/ready handshake and reads a 32x32 register file.
- Resolves read-after-write hazards with a busy scoreboard plus same-cycle writeback forwarding.
- Presents registered alu_op/op_a/op_b to the ALU, with a result tag rd, over a valid/ready handshake.
- The ALU result returns through the writeback port.

Parameters:
- DATA_W, 32, operand and register width
- OP_W, 5, ALU opcode width
- ADDR_W, 5, register index width; register count = 2**ADDR_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts instruction this cycle
- in_alu_op  input  OP_W  ALU opcode, passed through unchanged
- in_rs1  input  ADDR_W  source register for op_a
- in_rs2  input  ADDR_W  source register for op_b
- in_rd  input  ADDR_W  destination register; 0 = no writeback
- in_imm  input  DATA_W  immediate value
- in_use_imm  input  1  1: op_b = in_imm; rs2 ignored
- out_valid  output  1  operands valid to ALU
- out_ready  input  1  ALU side accepts operands
- alu_op  output  OP_W  registered opcode
- op_a  output  DATA_W  registered operand A
- op_b  output  DATA_W  registered operand B
- out_rd  output  ADDR_W  registered destination tag
- wb_en  input  1  writeback strobe
- wb_rd  input  ADDR_W  writeback register
- wb_data  input  DATA_W  writeback data

Behaviour:
- Reset (sync, rst=1 at posedge):
  - out_valid, alu_op, op_a, op_b and out_rd all go to 0.
  - All registers are cleared to 0 and all busy bits are cleared.
  - Reset overrides every same-cycle transfer or writeback, including mid-stall.
- Register 0:
  - Reads as 0.
  - Writes to it are ignored and its busy bit is never set.
- Hazard (combinational) is asserted when, for a source that is used (rs1 always; rs2 only when in_use_imm=0) and nonzero:
  - busy[rs] is set, and
  - the same cycle does not have wb_en && wb_rd==rs.
  - WAW: hazard is also asserted if busy[in_rd] is set with in_rd!=0, unless it is cleared by wb this cycle.
- in_ready = (!out_valid || out_ready) && !hazard.
  - Depends on in_* inputs; no internal state machine beyond the pipeline register.
- Forwarding: when wb_en && wb_rd==rs && rs!=0, the operand takes wb_data (write-first); otherwise it takes the register file value.
- Accept (in_valid && in_ready) at posedge:
  - alu_op, op_a, op_b and out_rd load; out_valid becomes 1.
  - Latency: 1 cycle from accept to out_valid.
  - busy[in_rd] is set if in_rd!=0.
- Output stall: while out_valid && !out_ready, all outputs hold stable.
- Drain: out_valid && out_ready with no new accept clears out_valid; data outputs may hold their last value.
- Throughput: one instruction per cycle when there is no hazard and out_ready=1.
- Writeback at posedge, when wb_en && wb_rd!=0:
  - regs[wb_rd] <= wb_data; busy[wb_rd] cleared.
  - A writeback to a non-busy register is still written.
- Same-cycle set and clear of the same busy bit (accept with in_rd==wb_rd): set wins.
- Width: no arithmetic; all fields pass through unmodified; DATA_W bits are copied exactly.

Test Plan:
- Reset, then write r1=3 and r2=1 via wb; issue alu_op=5'b01010, rs1=1, rs2=2, rd=3 -> next cycle out_valid=1, op_a=32'h3, op_b=32'h1, alu_op=5'b01010, out_rd=3.
- Back-to-back RAW: issue rd=3, then rs1=3 -> in_ready=0 until the wb for r3 is applied. When wb_en=1, wb_rd=3, wb_data=32'h4 arrives in the stall cycle -> accepted that cycle with op_a=32'h4 (forwarded).
- Immediate: in_use_imm=1, in_imm=32'hFFFF_FFF0, rs2=5 with busy[5] set -> no stall; op_b=32'hFFFF_FFF0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs hold, in_ready=0; out_ready=1 -> next instruction loads the following cycle.
- Register 0: wb_rd=0 with wb_data=32'hDEAD_BEEF, then rs1=0 -> op_a=0; issue with rd=0 -> a subsequent rs1=0 does not stall.
- Reset mid-stall: busy[3] set and out_valid=1, assert rst one cycle -> out_valid=0, in_ready=1; rs1=3 is then accepted immediately with op_a=0.
